// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller.
// Covers the state encoding, the default memory latency and the wait-counter width.
package pipe_ctrl_pkg;

    localparam int CNT_W       = 4;
    localparam int MEM_LAT_DEF = 2;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

endpackage

// File: rtl/pipe_ctrl_wait_cnt.sv
// Loadable down-counter that times the memory-busy stall.
// It holds at zero instead of wrapping.
module pipe_ctrl_wait_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for a 5-stage pipeline sharing one memory port.
// Define PIPE_CTRL_PERF_EN to add the saturating stall_cnt performance counter.
//
// state     | meaning
// RUN       | normal issue; hazards decoded into loads/flushes
// MEM_WAIT  | MEM stage owns memory; pipeline frozen until cnt reaches 0
// HALTED    | ecall/ebreak/fence reached EX; frozen until rst
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_hazard,
    input  logic        br_taken,
    input  logic        mem_req,
    input  logic        halt,
    output logic        pc_load,
    output logic        if_id_load,
    output logic        id_ex_load,
    output logic        ex_mem_load,
    output logic        mem_wb_load,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_sel,
    output logic        mem_done
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [1:0]       st;
    logic [4:0]       load_vec;
    logic [1:0]       flush_vec;
    logic             sel;
    logic             done;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;

    // While rst is high the outputs already show the RUN decode.
    assign st = rst ? ST_RUN : state_q;

    always_comb begin
        state_d   = state_q;
        load_vec  = 5'b00000;
        flush_vec = 2'b00;
        sel       = 1'b0;
        done      = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (st)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (mem_req) begin
                    sel      = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else begin
                    load_vec = 5'b11111;
                    if (br_taken) begin
                        flush_vec = 2'b11;
                    end else if (lu_hazard) begin
                        load_vec  = 5'b00111;
                        flush_vec = 2'b01;
                    end
                end
            end
            ST_MEM_WAIT: begin
                sel = 1'b1;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    // Data is valid; halt/mem_req wait for the next RUN cycle.
                    done     = 1'b1;
                    state_d  = ST_RUN;
                    load_vec = 5'b11111;
                    if (br_taken) begin
                        flush_vec = 2'b11;
                    end else if (lu_hazard) begin
                        load_vec  = 5'b00111;
                        flush_vec = 2'b01;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_ctrl_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_LAT - 1)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    assign {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = load_vec;
    assign {if_id_flush, id_ex_flush} = flush_vec;
    assign mem_sel  = sel;
    assign mem_done = done;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!load_vec[4] && (st != ST_HALTED) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule
